// File: rtl/layer2_result_collector_if.sv
// Issue/result handshake bundle between the dot-product issue logic, the
// result collector and the next-layer consumer.
interface layer2_result_collector_if #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 15
) ();
  logic             issue_valid;
  logic             issue_last;
  logic             issue_ready;
  logic [IN_W-1:0]  dp_out;
  logic             res_valid;
  logic             res_ready;
  logic [OUT_W-1:0] res_data;

  // Environment side: issues operands, supplies dp_out, consumes results.
  modport master (
    output issue_valid, issue_last, dp_out, res_ready,
    input  issue_ready, res_valid, res_data
  );

  // Collector side.
  modport slave (
    input  issue_valid, issue_last, dp_out, res_ready,
    output issue_ready, res_valid, res_data
  );
endinterface

// File: rtl/layer2_result_collector.sv
// Accumulates dot-product partial sums per node, then applies ReLU, shift and
// saturation, and buffers the 15-bit results in a small ready/valid FIFO.
module layer2_result_collector #(
  parameter int IN_W      = 21,
  parameter int OUT_W     = 15,
  parameter int MAX_BEATS = 8,
  parameter int SHIFT     = 4,
  parameter int DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  layer2_result_collector_if.slave     bus,
  input  logic                         relu_en,
  output logic                         beat_err,
  output logic                         busy
);

  localparam int ACC_W = IN_W + $clog2(MAX_BEATS);
  localparam int BC_W  = $clog2(MAX_BEATS + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);
  localparam logic [BC_W-1:0]         BEATS_MAX = BC_W'(MAX_BEATS);
  localparam logic [CNT_W:0]          DEPTH_V   = (CNT_W + 1)'(DEPTH);

  // Issue stage: dp_out for an issued beat arrives one cycle later.
  logic cap_v_q, cap_last_q;
  logic issue_fire;

  logic [0:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [BC_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic                    beat_err_q, beat_err_d;

  logic signed [ACC_W-1:0] dp_ext, base, sum, relu_v, shifted;
  logic [OUT_W-1:0]        fin_data;
  logic                    cnt_full, push, pop;

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic [OUT_W-1:0] hold_q;
  logic [CNT_W:0]   occupancy;

  assign issue_fire = bus.issue_valid && bus.issue_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_v_q    <= 1'b0;
      cap_last_q <= 1'b0;
    end else begin
      cap_v_q    <= issue_fire;
      cap_last_q <= issue_fire && bus.issue_last;
    end
  end

  assign dp_ext   = {{(ACC_W - IN_W){bus.dp_out[IN_W-1]}}, bus.dp_out};
  assign base     = (state_q == ST_ACC) ? acc_q : '0;
  assign sum      = base + dp_ext;
  assign cnt_full = (beat_cnt_q >= BEATS_MAX);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    beat_err_d = beat_err_q;
    if (cap_v_q) begin
      if (cnt_full) beat_err_d = 1'b1;
      if (cap_last_q) begin
        state_d    = ST_IDLE;
        acc_d      = '0;
        beat_cnt_d = '0;
      end else begin
        state_d    = ST_ACC;
        acc_d      = sum;
        beat_cnt_d = cnt_full ? beat_cnt_q : beat_cnt_q + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      beat_cnt_q <= '0;
      beat_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
      beat_err_q <= beat_err_d;
    end
  end

  // Finalise: ReLU, floor shift, saturate to the feature format.
  assign relu_v  = (relu_en && sum[ACC_W-1]) ? '0 : sum;
  assign shifted = relu_v >>> SHIFT;

  always_comb begin
    fin_data = shifted[OUT_W-1:0];
    if (shifted > SAT_HI)      fin_data = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) fin_data = SAT_LO[OUT_W-1:0];
  end

  assign push = cap_v_q && cap_last_q;
  assign pop  = (fifo_cnt_q != '0) && bus.res_ready;

  // NOTE: the FIFO storage has no reset; validity comes from the count, and
  // the head mux shows hold_q whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fin_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      hold_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        hold_q   <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Reserve a slot for a last beat still in the capture stage so a push
  // never meets a full FIFO.
  assign occupancy = {1'b0, fifo_cnt_q} + {{CNT_W{1'b0}}, (cap_v_q && cap_last_q)};

  assign bus.issue_ready = (occupancy < DEPTH_V);
  assign bus.res_valid   = (fifo_cnt_q != '0);
  assign bus.res_data    = (fifo_cnt_q != '0) ? mem_q[rd_ptr_q] : hold_q;
  assign beat_err        = beat_err_q;
  assign busy            = (state_q == ST_ACC) || cap_v_q;

endmodule
